if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS core: the initiator side of the instruction-memory read interface. Each cycle it owns the PC, drives `memread`/`address` into the word-indexed instruction memory bank, captures the returned word into the IF/ID pipeline register, and applies stall, flush, branch and jump redirects from downstream stages. It sits between the hazard/branch logic and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_0000, byte address fetched first after reset
- `IMEM_WORDS`, 256, instruction memory depth in 32-bit words

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `flush`  in  1  replace IF/ID contents with a bubble
- `branch_taken`  in  1  EX-stage taken branch
- `branch_target`  in  32  byte address of the branch destination
- `jump`  in  1  ID-stage `j` decoded
- `jump_index`  in  26  instr[25:0] of the jump
- `halt`  in  1  ID-stage halt request
- `memread`  out  1  read enable to instruction memory
- `address`  out  32  byte address to instruction memory (memory indexes `address>>2`)
- `readdata`  in  32  combinational instruction word from memory
- `pc`  out  32  current fetch PC
- `if_id_instr`  out  32  latched instruction
- `if_id_pc4`  out  32  latched PC+4
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `addr_err`  out  1  sticky: misaligned or out-of-range fetch attempted
- `fetch_count`  out  32  instructions captured into IF/ID

## Operation
- FSM states: `BOOT` (held during reset and for one cycle after), `RUN`, `HALTED`.
- `BOOT`: `memread`=0, PC=`RESET_PC`; next cycle -> `RUN`.
- `RUN`: `memread`=1, `address`=`pc`. Next-PC priority, highest first:
  1. `branch_taken`: PC <- `branch_target`; IF/ID bubbled. Overrides `stall`.
  2. `jump` && !`stall`: PC <- {`if_id_pc4`[31:28], `jump_index`, 2'b00}; IF/ID bubbled.
  3. `stall`: PC and IF/ID hold.
  4. otherwise: PC <- PC+4; IF/ID <- {`readdata`, PC+4, valid=1}; `fetch_count`++.
- `flush` without redirect: PC advances normally; IF/ID bubbled (instr=0, valid=0). `flush` wins over `stall` for IF/ID; PC still holds under `stall`.
- Bubble = instr 32'h0 (sll $0 nop), pc4 unchanged, valid=0; bubbles do not increment `fetch_count`.
- Redirect target with bits[1:0]≠0: low bits forced to 0, `addr_err` set. Target ≥ 4*`IMEM_WORDS`: fetch proceeds, `addr_err` set, captured instr forced to 0, valid=0.
- `halt` && !`stall` && !`branch_taken`: -> `HALTED`; IF/ID bubbled, `memread`=0, PC frozen; only reset exits.
- PC arithmetic 32-bit modulo, wraps 32'hFFFF_FFFC -> 0.

## Timing
- Reset (async, immediate): `pc`=`RESET_PC`, `memread`=0, `if_id_instr`=0, `if_id_pc4`=0, `if_id_valid`=0, `addr_err`=0, `fetch_count`=0, state `BOOT`.
- First `memread`=1 in the second cycle after `rst_n` rises; first valid IF/ID at the edge ending that cycle.
- Fetch latency: word at PC appears on `if_id_instr` one edge after PC is presented.
- Redirect penalty: branch = 2 bubbles to ID (IF/ID + ID/EX flushed by hazard unit); jump = 1 bubble.
- `address`, `memread` are functions of registered state only; no combinational path from any input to `address`.
- Reset mid-run: all state clears the same cycle; pending redirects discarded.

## Structure
- Shared package `mips_pkg`: `NOP_INSTR`, `RESET_PC` default, fetch FSM state enum, `IMEM_WORDS`.
- One sub-module `pc_next_sel`: combinational next-PC / bubble / error selection; the top holds registers and FSM.

## Test plan
- Reset release, memory holds 0x11..0x44 at words 0-3 -> `memread` rises in cycle 2; IF/ID shows 0x11, 0x22, 0x33 with pc4 4, 8, 12; `fetch_count`=3.
- `stall` held 3 cycles at PC=8 -> `pc`=8 and IF/ID unchanged throughout; resumes with word 2.
- `branch_taken` with target 0x20 simultaneous with `stall` -> next `pc`=0x20, `if_id_valid`=0 that cycle, then word 8.
- `jump` with `jump_index`=4 and `if_id_pc4`=0x1C -> `pc`=0x10; same with `stall`=1 -> ignored.
- Branch target 0x22 -> `pc`=0x20, `addr_err`=1 sticky; target 0x400 (IMEM_WORDS=256) -> `if_id_valid`=0, `addr_err`=1.
- `halt` at PC=0x0C -> `memread`=0, `pc` frozen at 0x0C, `fetch_count` constant; async reset mid-halt -> all outputs at reset values immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS fetch stage.
// Holds the NOP encoding, the reset PC default, the instruction-memory depth,
// the fetch FSM state codes and a range-check helper.
package mips_pkg;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_WORDS = 256;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Word-index compare, so 4*words never overflows.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned words);
        return addr[31:2] < 30'(words);
    endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory read bus.
// memread/address are driven by the fetch stage (master);
// readdata is the combinational word returned by memory (slave).
interface if_fetch_stage_if;
    logic        memread;
    logic [31:0] address;
    logic [31:0] readdata;

    modport master (output memread, address, input readdata);
    modport slave  (input memread, address, output readdata);
endinterface

// File: rtl/if_fetch_stage_pc_next_sel.sv
// pc_next_sel: combinational next-PC, IF/ID bubble and address-error selection.
// Inputs : current pc, IF/ID pc4, memory word, stall/flush/branch/jump/halt controls.
// Outputs: next pc, IF/ID write enable and next contents, count increment,
//          address-error set, halt request accepted.
module pc_next_sel #(
    parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS
) (
    input  logic [31:0] pc_i,
    input  logic [31:0] if_id_pc4_i,
    input  logic [31:0] readdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        halt_i,
    output logic [31:0] pc_d_o,
    output logic        ifid_we_o,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc4_d_o,
    output logic        valid_d_o,
    output logic        count_inc_o,
    output logic        err_set_o,
    output logic        halt_o
);
    import mips_pkg::*;

    logic        jmp, hlt, redirect, adv, oor;
    logic [31:0] tgt, pc_plus4;

    always_comb begin
        // Taken branch beats everything; halt and jump only act when not stalled.
        hlt         = halt_i && !stall_i && !branch_taken_i;
        jmp         = jump_i && !stall_i && !branch_taken_i && !halt_i;
        redirect    = branch_taken_i || jmp;
        tgt         = branch_taken_i ? branch_target_i : {if_id_pc4_i[31:28], jump_index_i, 2'b00};
        pc_plus4    = pc_i + 32'd4;
        oor         = !in_range(pc_i, IMEM_WORDS);
        adv         = !redirect && !hlt && !stall_i && !flush_i;
        pc_d_o      = redirect ? {tgt[31:2], 2'b00} : (hlt || stall_i) ? pc_i : pc_plus4;
        // Flush bubbles IF/ID even while the PC is held by a stall.
        ifid_we_o   = redirect || hlt || flush_i || !stall_i;
        valid_d_o   = adv && !oor;
        instr_d_o   = valid_d_o ? readdata_i : NOP_INSTR;
        pc4_d_o     = adv ? pc_plus4 : if_id_pc4_i;
        count_inc_o = valid_d_o;
        err_set_o   = (redirect && (tgt[1:0] != 2'b00 || !in_range(tgt, IMEM_WORDS))) || (adv && oor);
        halt_o      = hlt;
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction-fetch stage with PC, IF/ID register and BOOT/RUN/HALTED FSM.
// Ports: clk, rst_n (async active-low); stall, flush, branch_taken/branch_target,
//        jump/jump_index, halt from hazard/branch logic; imem bus (memread, address,
//        readdata); pc, if_id_instr, if_id_pc4, if_id_valid, addr_err (sticky), fetch_count.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_target,
    input  logic                   jump,
    input  logic [25:0]            jump_index,
    input  logic                   halt,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            pc,
    output logic [31:0]            if_id_instr,
    output logic [31:0]            if_id_pc4,
    output logic                   if_id_valid,
    output logic                   addr_err,
    output logic [31:0]            fetch_count
);
    import mips_pkg::*;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, cnt_q, cnt_d;
    logic        valid_q, valid_d, err_q, err_d, run;
    logic [31:0] sel_pc, sel_instr, sel_pc4;
    logic        sel_we, sel_valid, sel_inc, sel_err, sel_halt;

    pc_next_sel #(.IMEM_WORDS(IMEM_WORDS)) u_sel (
        .pc_i           (pc_q),
        .if_id_pc4_i    (pc4_q),
        .readdata_i     (imem.readdata),
        .stall_i        (stall),
        .flush_i        (flush),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .jump_i         (jump),
        .jump_index_i   (jump_index),
        .halt_i         (halt),
        .pc_d_o         (sel_pc),
        .ifid_we_o      (sel_we),
        .instr_d_o      (sel_instr),
        .pc4_d_o        (sel_pc4),
        .valid_d_o      (sel_valid),
        .count_inc_o    (sel_inc),
        .err_set_o      (sel_err),
        .halt_o         (sel_halt)
    );

    always_comb begin
        run     = state_q == ST_RUN;
        state_d = (state_q == ST_BOOT) ? ST_RUN : (run && sel_halt) ? ST_HALTED : state_q;
        pc_d    = run ? sel_pc : pc_q;
        instr_d = (run && sel_we) ? sel_instr : instr_q;
        pc4_d   = (run && sel_we) ? sel_pc4 : pc4_q;
        valid_d = (run && sel_we) ? sel_valid : valid_q;
        err_d   = err_q || (run && sel_err);
        cnt_d   = cnt_q + 32'(run && sel_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory bus depends on registered state only.
    assign imem.memread = run;
    assign imem.address = pc_q;
    assign pc           = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign addr_err     = err_q;
    assign fetch_count  = cnt_q;
endmodule
